full_adder_bit: RTL and testbench



---
 rtl/full_adder_bit.sv | 123 ++++++++++++
 tb/tb_full_adder_bit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/full_adder_bit.sv
// Registered WIDTH-bit ripple full adder producing sum, carry-out and signed overflow.
// Define FULL_ADDER_BIT_INREG_EN to add an input register stage (2-cycle latency).
module full_adder_bit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             out_valid
);

  function automatic logic [WIDTH:0] ripple_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic             cin);
    logic [WIDTH:0]   cy;
    logic [WIDTH-1:0] sum;
    cy[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]  = x[i] ^ y[i] ^ cy[i];
      cy[i+1] = (x[i] & y[i]) | (x[i] & cy[i]) | (y[i] & cy[i]);
    end
    return {cy[WIDTH], sum};
  endfunction

  function automatic logic signed_ovf(input logic xs, input logic ys, input logic ss);
    return (xs ~^ ys) & (ss ^ xs);
  endfunction

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_c;
  logic             add_vld;

`ifdef FULL_ADDER_BIT_INREG_EN
  logic [WIDTH-1:0] a_p0_d, a_p0_q;
  logic [WIDTH-1:0] b_p0_d, b_p0_q;
  logic             c_p0_d, c_p0_q;
  logic             vld_p0_d, vld_p0_q;

  // Stage p0: operand capture; data loads only on valid, valid always loads
  always_comb begin
    a_p0_d   = a_p0_q;
    b_p0_d   = b_p0_q;
    c_p0_d   = c_p0_q;
    vld_p0_d = in_valid;
    if (in_valid) begin
      a_p0_d = a;
      b_p0_d = b;
      c_p0_d = c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0_q   <= '0;
      b_p0_q   <= '0;
      c_p0_q   <= 1'b0;
      vld_p0_q <= 1'b0;
    end else begin
      a_p0_q   <= a_p0_d;
      b_p0_q   <= b_p0_d;
      c_p0_q   <= c_p0_d;
      vld_p0_q <= vld_p0_d;
    end
  end

  assign add_a   = a_p0_q;
  assign add_b   = b_p0_q;
  assign add_c   = c_p0_q;
  assign add_vld = vld_p0_q;
`else
  assign add_a   = a;
  assign add_b   = b;
  assign add_c   = c;
  assign add_vld = in_valid;
`endif

  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] s_p1_d, s_p1_q;
  logic             co_p1_d, co_p1_q;
  logic             ovf_p1_d, ovf_p1_q;
  logic             vld_p1_d, vld_p1_q;

  // Stage p1: result register; holding on !valid keeps unknown operands out of state
  always_comb begin
    sum_full = ripple_add(add_a, add_b, add_c);
    s_p1_d   = s_p1_q;
    co_p1_d  = co_p1_q;
    ovf_p1_d = ovf_p1_q;
    vld_p1_d = add_vld;
    if (add_vld) begin
      s_p1_d   = sum_full[WIDTH-1:0];
      co_p1_d  = sum_full[WIDTH];
      ovf_p1_d = signed_ovf(add_a[WIDTH-1], add_b[WIDTH-1], sum_full[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_p1_q   <= '0;
      co_p1_q  <= 1'b0;
      ovf_p1_q <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      s_p1_q   <= s_p1_d;
      co_p1_q  <= co_p1_d;
      ovf_p1_q <= ovf_p1_d;
      vld_p1_q <= vld_p1_d;
    end
  end

  assign s         = s_p1_q;
  assign co        = co_p1_q;
  assign ovf       = ovf_p1_q;
  assign out_valid = vld_p1_q;

endmodule

// File: tb/tb_full_adder_bit.sv
// Directed bench for full_adder_bit at WIDTH=4; honours FULL_ADDER_BIT_INREG_EN for latency.
module tb_full_adder_bit;
  localparam int W = 4;
`ifdef FULL_ADDER_BIT_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c = 1'b0;
  logic [W-1:0] s;
  logic         co;
  logic         ovf;
  logic         out_valid;

  int ncomp = 0;
  int nfail = 0;

  // Hand-computed vectors: a, b, c -> s, co, ovf
  logic [W-1:0] va   [N] = '{4'h0, 4'h0, 4'h2, 4'hF, 4'hF, 4'h7, 4'h8, 4'h5};
  logic [W-1:0] vb   [N] = '{4'h0, 4'h0, 4'h4, 4'h0, 4'hF, 4'h1, 4'h8, 4'h3};
  logic         vc   [N] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [W-1:0] es   [N] = '{4'h0, 4'h1, 4'h6, 4'h0, 4'hF, 4'h8, 4'h0, 4'h9};
  logic         eco  [N] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic         eovf [N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  full_adder_bit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
    .s(s), .co(co), .ovf(ovf), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exhausted, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] xs, input logic xco,
                           input logic xovf, input logic xvld);
    check({tag, ".s"},   32'(s),         32'(xs));
    check({tag, ".co"},  32'(co),        32'(xco));
    check({tag, ".ovf"}, 32'(ovf),       32'(xovf));
    check({tag, ".vld"}, 32'(out_valid), 32'(xvld));
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    a = 'x;
    b = 'x;
    c = 1'bx;
  endtask

  // One isolated transaction: present vector i, then check after exactly LAT edges
  task automatic single(input int i, input string tag);
    @(negedge clk);
    a = va[i]; b = vb[i]; c = vc[i]; in_valid = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    check({tag, ".early_vld"}, 32'(out_valid), (LAT == 1) ? 32'd1 : 32'd0);
    for (int k = 1; k < LAT; k++) begin
      @(posedge clk); #1;
    end
    check_out(tag, es[i], eco[i], eovf[i], 1'b1);
  endtask

  initial begin
    // Asynchronous reset assertion, observed before any clock edge acts
    #2 rst_n = 1'b0;
    #1 check_out("reset_async", '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    single(0, "zero");
    single(1, "cin_only");
    single(2, "two_plus_four");
    single(3, "wrap_carry");
    single(4, "all_ones");
    single(5, "pos_ovf");

    // Holding with in_valid low and unknown operands
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_out("hold", 4'h8, 1'b0, 1'b1, 1'b0);
    end

    // Back-to-back stream: vector j enters before edge j, emerges after edge j+LAT-1
    @(negedge clk);
    for (int j = 0; j < N + LAT; j++) begin
      if (j < N) begin
        a = va[j]; b = vb[j]; c = vc[j]; in_valid = 1'b1;
      end else begin
        idle_inputs();
      end
      @(posedge clk); #1;
      if (j - LAT + 1 >= 0 && j - LAT + 1 < N)
        check_out("stream", es[j-LAT+1], eco[j-LAT+1], eovf[j-LAT+1], 1'b1);
      else if (j - LAT + 1 >= N)
        check_out("stream_end", es[N-1], eco[N-1], eovf[N-1], 1'b0);
    end

    // Mid-stream reset between edges discards result and in-flight data
    a = va[2]; b = vb[2]; c = vc[2]; in_valid = 1'b1;
    for (int k = 0; k < LAT; k++) begin
      @(posedge clk); #1;
    end
    a = va[6]; b = vb[6]; c = vc[6];
    check_out("pre_reset", es[2], eco[2], eovf[2], 1'b1);
    #1 rst_n = 1'b0;
    #1 check_out("reset_mid", '0, 1'b0, 1'b0, 1'b0);
    idle_inputs();
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < LAT; k++) begin
      @(posedge clk); #1;
      check_out("post_reset", '0, 1'b0, 1'b0, 1'b0);
    end

    single(6, "neg_ovf");
    single(7, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
